// File: rtl/reg_spill_fill_if.sv
// Memory-side handshake bundle of the register spill/fill engine.
// The engine drives the request side (master); the data memory answers (slave).
interface reg_spill_fill_if #(
   parameter int DATA_W = 16
);
   logic              mem_req;
   logic              mem_we;
   logic [15:0]       mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      output mem_req,
      output mem_we,
      output mem_addr,
      output mem_wdata,
      input  mem_ack,
      input  mem_rdata
   );

   modport slave (
      input  mem_req,
      input  mem_we,
      input  mem_addr,
      input  mem_wdata,
      output mem_ack,
      output mem_rdata
   );
endinterface

// File: rtl/reg_spill_fill.sv
// Spill/fill engine: copies a contiguous, wrapping register range to data memory
// (save) or back into the register file (restore), one register per transaction.
module reg_spill_fill #(
   parameter int DATA_W   = 16,
   parameter int NUM_REGS = 16,
   parameter int IDX_W    = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              mode,
   input  logic [3:0]        first_reg,
   input  logic [4:0]        count,
   input  logic [15:0]       base_addr,
   output logic              busy,
   output logic              done,
   output logic [IDX_W-1:0]  rf_rd_idx,
   input  logic [DATA_W-1:0] rf_rd_data,
   output logic              rf_wr_en,
   output logic [IDX_W-1:0]  rf_wr_idx,
   output logic [DATA_W-1:0] rf_wr_data,
   reg_spill_fill_if.master  mem
);

   localparam int IDX_BITS = $clog2(NUM_REGS);
   localparam int CNT_W    = $clog2(NUM_REGS + 1);

   typedef enum logic [2:0] {
      IDLE,
      SAVE_RD,
      SAVE_REQ,
      RST_REQ,
      RST_WB,
      DONE
   } state_e;

   state_e              state_q, state_d;
   logic [IDX_BITS-1:0] idx_q, idx_d;
   logic [15:0]         addr_q, addr_d;
   logic [CNT_W-1:0]    remaining_q, remaining_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                mem_req_q, mem_req_d;
   logic                mem_we_q, mem_we_d;
   logic [15:0]         mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic                rf_wr_en_q, rf_wr_en_d;
   logic [IDX_BITS-1:0] rf_wr_idx_q, rf_wr_idx_d;
   logic [DATA_W-1:0]   rf_wr_data_q, rf_wr_data_d;

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      addr_d       = addr_q;
      remaining_d  = remaining_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      mem_req_d    = mem_req_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      rf_wr_en_d   = 1'b0;
      rf_wr_idx_d  = rf_wr_idx_q;
      rf_wr_data_d = rf_wr_data_q;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               idx_d       = IDX_BITS'(first_reg);
               addr_d      = base_addr;
               remaining_d = (int'(count) > NUM_REGS) ? CNT_W'(NUM_REGS) : CNT_W'(count);
               busy_d      = 1'b1;
               if (count == 5'd0) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else if (mode) begin
                  // Restore issues its read request on the same edge that leaves IDLE.
                  state_d    = RST_REQ;
                  mem_req_d  = 1'b1;
                  mem_we_d   = 1'b0;
                  mem_addr_d = base_addr;
               end else begin
                  state_d = SAVE_RD;
               end
            end
         end

         SAVE_RD: begin
            mem_wdata_d = rf_rd_data;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = addr_q;
            state_d     = SAVE_REQ;
         end

         SAVE_REQ: begin
            if (mem.mem_ack) begin
               mem_req_d   = 1'b0;
               mem_we_d    = 1'b0;
               remaining_d = remaining_q - CNT_W'(1);
               if (remaining_q == CNT_W'(1)) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else begin
                  idx_d   = idx_q + IDX_BITS'(1);
                  addr_d  = addr_q + 16'd1;
                  state_d = SAVE_RD;
               end
            end
         end

         RST_REQ: begin
            if (mem.mem_ack) begin
               mem_req_d    = 1'b0;
               rf_wr_data_d = mem.mem_rdata;
               rf_wr_idx_d  = idx_q;
               rf_wr_en_d   = 1'b1;
               state_d      = RST_WB;
            end
         end

         RST_WB: begin
            remaining_d = remaining_q - CNT_W'(1);
            if (remaining_q == CNT_W'(1)) begin
               state_d = DONE;
               done_d  = 1'b1;
            end else begin
               idx_d      = idx_q + IDX_BITS'(1);
               addr_d     = addr_q + 16'd1;
               mem_req_d  = 1'b1;
               mem_we_d   = 1'b0;
               mem_addr_d = addr_q + 16'd1;
               state_d    = RST_REQ;
            end
         end

         DONE: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end

         default: begin
            state_d   = IDLE;
            busy_d    = 1'b0;
            mem_req_d = 1'b0;
            mem_we_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         idx_q        <= '0;
         addr_q       <= '0;
         remaining_q  <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         rf_wr_en_q   <= 1'b0;
         rf_wr_idx_q  <= '0;
         rf_wr_data_q <= '0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         addr_q       <= addr_d;
         remaining_q  <= remaining_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         rf_wr_en_q   <= rf_wr_en_d;
         rf_wr_idx_q  <= rf_wr_idx_d;
         rf_wr_data_q <= rf_wr_data_d;
      end
   end

   assign busy          = busy_q;
   assign done          = done_q;
   assign rf_rd_idx     = IDX_W'(idx_q);
   assign rf_wr_en      = rf_wr_en_q;
   assign rf_wr_idx     = IDX_W'(rf_wr_idx_q);
   assign rf_wr_data    = rf_wr_data_q;
   assign mem.mem_req   = mem_req_q;
   assign mem.mem_we    = mem_we_q;
   assign mem.mem_addr  = mem_addr_q;
   assign mem.mem_wdata = mem_wdata_q;

   // Invariants of the handshake and the write-back pulse.
   a_we_needs_req : assert property (@(posedge clk) disable iff (!rst_n) mem.mem_we |-> mem.mem_req);
   a_wr_one_cycle : assert property (@(posedge clk) disable iff (!rst_n) rf_wr_en |=> !rf_wr_en);
   a_done_busy    : assert property (@(posedge clk) disable iff (!rst_n) done |-> busy);
   a_wr_no_req    : assert property (@(posedge clk) disable iff (!rst_n) !(rf_wr_en && mem.mem_req));

endmodule

// File: tb/tb_reg_spill_fill.sv
// Directed bench for reg_spill_fill: register-file and memory models plus a
// negedge monitor that logs accepted writes and handshake stability.
module tb_reg_spill_fill;
   localparam int DATA_W   = 16;
   localparam int NUM_REGS = 16;
   localparam int IDX_W    = 16;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic              start = 1'b0;
   logic              mode = 1'b0;
   logic [3:0]        first_reg = '0;
   logic [4:0]        count = '0;
   logic [15:0]       base_addr = '0;
   logic              busy, done, rf_wr_en;
   logic [IDX_W-1:0]  rf_rd_idx, rf_wr_idx;
   logic [DATA_W-1:0] rf_rd_data, rf_wr_data;

   reg_spill_fill_if #(.DATA_W(DATA_W)) mem_if ();

   reg_spill_fill #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .IDX_W(IDX_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .mode       (mode),
      .first_reg  (first_reg),
      .count      (count),
      .base_addr  (base_addr),
      .busy       (busy),
      .done       (done),
      .rf_rd_idx  (rf_rd_idx),
      .rf_rd_data (rf_rd_data),
      .rf_wr_en   (rf_wr_en),
      .rf_wr_idx  (rf_wr_idx),
      .rf_wr_data (rf_wr_data),
      .mem        (mem_if)
   );

   always #5 clk = ~clk;

   // Register file model
   logic [DATA_W-1:0] rf      [NUM_REGS];
   logic [DATA_W-1:0] rf_init [NUM_REGS];
   logic              rf_load = 1'b0;

   always @(posedge clk) begin
      if (rf_load) rf <= rf_init;
      else if (rf_wr_en) rf[rf_wr_idx[3:0]] <= rf_wr_data;
   end
   assign rf_rd_data = rf[rf_rd_idx[3:0]];

   // Memory model: wait_cfg=0 ties ack high, otherwise ack after wait_cfg counted cycles
   int   wait_cfg = 0;
   int   wait_cnt = 0;
   logic force_ack = 1'b0;

   always @(posedge clk)
      wait_cnt <= (mem_if.mem_req && !mem_if.mem_ack) ? wait_cnt + 1 : 0;

   assign mem_if.mem_ack   = force_ack || (wait_cfg == 0) || (mem_if.mem_req && (wait_cnt >= wait_cfg));
   assign mem_if.mem_rdata = 16'hA000 + mem_if.mem_addr;

   // Monitor
   logic        clr = 1'b0;
   int          req_cycles = 0, rfw_cnt = 0, stab_err = 0, we_err = 0;
   logic [15:0] wa_q[$];
   logic [15:0] wd_q[$];
   logic [15:0] ri_q[$];
   logic        prev_wait = 1'b0, prev_we = 1'b0;
   logic [15:0] prev_addr = '0, prev_wdata = '0;

   always @(negedge clk) begin
      if (clr) begin
         req_cycles <= 0;
         rfw_cnt    <= 0;
         stab_err   <= 0;
         we_err     <= 0;
         wa_q.delete();
         wd_q.delete();
         ri_q.delete();
      end else begin
         if (mem_if.mem_req) req_cycles <= req_cycles + 1;
         if (mem_if.mem_req && mem_if.mem_ack && mem_if.mem_we) begin
            wa_q.push_back(mem_if.mem_addr);
            wd_q.push_back(mem_if.mem_wdata);
            ri_q.push_back(rf_rd_idx);
         end
         if (rf_wr_en) rfw_cnt <= rfw_cnt + 1;
         if (mem_if.mem_we && !mem_if.mem_req) we_err <= we_err + 1;
         if (prev_wait && (!mem_if.mem_req || mem_if.mem_addr != prev_addr ||
                           mem_if.mem_we != prev_we || mem_if.mem_wdata != prev_wdata))
            stab_err <= stab_err + 1;
      end
      prev_wait  <= mem_if.mem_req && !mem_if.mem_ack;
      prev_addr  <= mem_if.mem_addr;
      prev_we    <= mem_if.mem_we;
      prev_wdata <= mem_if.mem_wdata;
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      clr = 1'b1;
      step();
      clr = 1'b0;
   endtask

   task automatic load_rf();
      rf_load = 1'b1;
      step();
      rf_load = 1'b0;
   endtask

   task automatic run_cmd(input logic m, input logic [3:0] fr, input logic [4:0] cnt,
                          input logic [15:0] base, input int poke_at, output int cycles);
      mode      = m;
      first_reg = fr;
      count     = cnt;
      base_addr = base;
      start     = 1'b1;
      cycles    = -1;
      for (int cyc = 1; cyc <= 300; cyc++) begin
         step();
         if (cyc == 1) start = 1'b0;
         if (cyc == poke_at) begin
            start     = 1'b1;
            mode      = ~m;
            first_reg = fr + 4'd5;
            count     = 5'd1;
            base_addr = 16'h7777;
         end else if (cyc == poke_at + 1) begin
            start = 1'b0;
         end
         if (done) begin
            cycles = cyc;
            break;
         end
      end
      start = 1'b0;
   endtask

   logic [15:0] exp_d3 [3];
   logic [15:0] wrap_idx [4];
   logic [15:0] wrap_addr [4];
   int          cyc;
   int          bad;

   initial begin
      for (int i = 0; i < NUM_REGS; i++) rf_init[i] = 16'h5000 + 16'(i);
      rf_init[3] = 16'h1111;
      rf_init[4] = 16'h2222;
      rf_init[5] = 16'h3333;
      exp_d3     = '{16'h1111, 16'h2222, 16'h3333};
      wrap_idx   = '{16'd14, 16'd15, 16'd0, 16'd1};
      wrap_addr  = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};

      // Reset
      #2 rst_n = 1'b0;
      repeat (3) step();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_mem_req", mem_if.mem_req, 0);
      check("rst_mem_we", mem_if.mem_we, 0);
      check("rst_mem_addr", mem_if.mem_addr, 0);
      check("rst_rf_wr_en", rf_wr_en, 0);
      check("rst_rd_idx", rf_rd_idx, 0);
      rst_n = 1'b1;
      load_rf();

      // Save, zero-wait
      wait_cfg = 0;
      clear_logs();
      run_cmd(1'b0, 4'd3, 5'd3, 16'h0100, 0, cyc);
      check("save_latency", cyc, 7);
      check("save_nwr", wa_q.size(), 3);
      for (int i = 0; i < 3; i++) begin
         check("save_addr", wa_q[i], 16'h0100 + 16'(i));
         check("save_data", wd_q[i], exp_d3[i]);
      end
      check("save_no_rfwr", rfw_cnt, 0);
      check("save_we_req", we_err, 0);
      step();
      check("save_done_fall", done, 0);
      check("save_busy_fall", busy, 0);

      // Restore with wait states
      wait_cfg   = 3;
      rf_init[0] = '0;
      rf_init[1] = '0;
      load_rf();
      clear_logs();
      run_cmd(1'b1, 4'd0, 5'd2, 16'h0040, 0, cyc);
      check("rst_latency", cyc, 11);
      check("rst_r0", rf[0], 16'hA040);
      check("rst_r1", rf[1], 16'hA041);
      check("rst_wr_pulses", rfw_cnt, 2);
      check("rst_stable", stab_err, 0);
      check("rst_req_cycles", req_cycles, 8);
      check("rst_no_memwr", wa_q.size(), 0);
      rf_init[0] = 16'h5000;
      rf_init[1] = 16'h5001;

      // Wrap of index and address
      wait_cfg = 0;
      load_rf();
      clear_logs();
      run_cmd(1'b0, 4'd14, 5'd4, 16'hFFFE, 0, cyc);
      check("wrap_latency", cyc, 9);
      check("wrap_nwr", wa_q.size(), 4);
      for (int i = 0; i < 4; i++) begin
         check("wrap_idx", ri_q[i], wrap_idx[i]);
         check("wrap_addr", wa_q[i], wrap_addr[i]);
         check("wrap_data", wd_q[i], rf_init[wrap_idx[i][3:0]]);
      end

      // count = 0
      clear_logs();
      run_cmd(1'b1, 4'd5, 5'd0, 16'h0300, 0, cyc);
      check("cnt0_latency", cyc, 1);
      check("cnt0_no_req", req_cycles, 0);
      check("cnt0_no_rfwr", rfw_cnt, 0);

      // count = 20 clamps to 16
      clear_logs();
      run_cmd(1'b0, 4'd0, 5'd20, 16'h0200, 0, cyc);
      check("cnt20_latency", cyc, 33);
      check("cnt20_nwr", wa_q.size(), 16);
      for (int i = 0; i < 16; i++) begin
         check("cnt20_idx", ri_q[i], 16'(i));
         check("cnt20_data", wd_q[i], rf_init[i]);
      end
      check("cnt20_last_addr", wa_q[15], 16'h020F);

      // start while busy is ignored
      wait_cfg = 2;
      clear_logs();
      run_cmd(1'b0, 4'd3, 5'd3, 16'h0100, 3, cyc);
      check("intf_latency", cyc, 13);
      check("intf_nwr", wa_q.size(), 3);
      for (int i = 0; i < 3; i++) begin
         check("intf_addr", wa_q[i], 16'h0100 + 16'(i));
         check("intf_data", wd_q[i], exp_d3[i]);
      end
      check("intf_no_rfwr", rfw_cnt, 0);
      check("intf_stable", stab_err, 0);
      step();
      check("intf_idle", busy, 0);

      // mem_ack in IDLE
      clear_logs();
      force_ack = 1'b1;
      repeat (3) step();
      force_ack = 1'b0;
      step();
      check("ack_idle_req", req_cycles, 0);
      check("ack_idle_busy", busy, 0);
      check("ack_idle_rfwr", rfw_cnt, 0);

      // Reset in the middle of a restore
      wait_cfg  = 3;
      mode      = 1'b1;
      first_reg = 4'd0;
      count     = 5'd4;
      base_addr = 16'h0040;
      start     = 1'b1;
      step();
      start = 1'b0;
      step();
      check("mid_pre_req", mem_if.mem_req, 1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_busy", busy, 0);
      check("mid_req", mem_if.mem_req, 0);
      check("mid_rfwr", rf_wr_en, 0);
      step();
      step();
      rst_n = 1'b1;
      bad = 0;
      repeat (4) begin
         step();
         if (busy || mem_if.mem_req || rf_wr_en) bad++;
      end
      check("mid_post_quiet", bad, 0);

      wait_cfg = 0;
      load_rf();
      clear_logs();
      run_cmd(1'b0, 4'd3, 5'd3, 16'h0100, 0, cyc);
      check("mid_new_latency", cyc, 7);
      check("mid_new_nwr", wa_q.size(), 3);
      check("mid_new_data", wd_q[2], 16'h3333);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/reg_spill_fill.md
Name: reg_spill_fill

Overview:
- Bus-initiator engine that drives the 16x16 register file's read and write ports.
- Saves ("spill") a contiguous, wrapping range of registers to data memory, or restores ("fill") them from memory, one register at a time.
- Sits between the control unit, the register file and the memory port. The control unit uses it for context save/restore on call, return and interrupt.

Parameters:
DATA_W, 16, register and memory data width
NUM_REGS, 16, register file depth; must be a power of two
IDX_W, 16, width of register-file index ports

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
start  in  1  one-cycle command strobe, sampled only in IDLE
mode  in  1  0 = save (regs to mem), 1 = restore (mem to regs)
first_reg  in  4  index of first register in range
count  in  5  number of registers to transfer, 0..31
base_addr  in  16  memory word address for first register
busy  out  1  high while a command is in progress
done  out  1  one-cycle pulse at command completion
rf_rd_idx  out  IDX_W  register-file read index; upper bits zero
rf_rd_data  in  DATA_W  register-file combinational read data
rf_wr_en  out  1  register-file write enable
rf_wr_idx  out  IDX_W  register-file write index; upper bits zero
rf_wr_data  out  DATA_W  register-file write data
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  1 = write, 0 = read; valid while mem_req
mem_addr  out  16  memory word address
mem_wdata  out  DATA_W  memory write data
mem_ack  in  1  memory completion; read data valid with it
mem_rdata  in  DATA_W  memory read data

Behaviour:
- One clock domain (clk). Reset is asynchronous and active-low (rst_n). All outputs are registered.
- Reset values: all outputs 0. State is IDLE. Internal idx, addr and remaining are 0.
- States: IDLE, SAVE_RD, SAVE_REQ, RST_REQ, RST_WB, DONE.
- IDLE, start=1:
  - Latch idx=first_reg and addr=base_addr.
  - Latch remaining = min(count,16); count above 16 is clamped to 16.
  - count=0: go to DONE; no register or memory access occurs.
  - Otherwise go to SAVE_RD (mode=0) or RST_REQ (mode=1).
- start outside IDLE is ignored, with no effect on the running command.
- busy=1 in every state except IDLE, including DONE.
- rf_rd_idx continuously reflects idx.
- SAVE_RD (1 cycle): capture rf_rd_data into mem_wdata. Next cycle: mem_req=1, mem_we=1, mem_addr=addr. Go to SAVE_REQ.
- SAVE_REQ:
  - Hold mem_req, mem_addr and mem_wdata stable until mem_ack=1.
  - On ack: mem_req=0, remaining-1. If remaining reaches 0 go to DONE; else idx+1, addr+1, go to SAVE_RD.
  - Minimum 2 cycles per register (zero-wait ack).
- RST_REQ:
  - mem_req=1, mem_we=0, mem_addr=addr; hold until mem_ack=1.
  - On ack: capture mem_rdata into rf_wr_data, rf_wr_idx=idx, go to RST_WB.
- RST_WB (1 cycle):
  - rf_wr_en=1 for exactly this cycle; mem_req=0.
  - remaining-1. If 0 go to DONE; else idx+1, addr+1, go to RST_REQ.
- DONE (1 cycle): done=1, then IDLE. done and busy fall together on the next edge.
- Wrap-around:
  - idx increments modulo NUM_REGS (first_reg=14, count=4 gives 14,15,0,1).
  - addr increments modulo 2^16 (0xFFFF then 0x0000).
- mem_ack while mem_req=0 is ignored.
- mem_ack may arrive in the first cycle mem_req is high.
- rf_wr_en is never asserted in save mode.
- mem_we is 0 whenever mem_req=0.
- Reset mid-command: immediate return to IDLE with all outputs 0.
  - A partially completed range is not resumed.
  - rf_wr_en must not be high in the cycle after rst_n deasserts.

Test Plan:
- Save, zero-wait: regs r3..r5 = 0x1111/0x2222/0x3333; start, mode=0, first_reg=3, count=3, base_addr=0x0100, mem_ack tied 1.
  - Required: writes (0x0100,0x1111), (0x0101,0x2222), (0x0102,0x3333).
  - done pulses 7 cycles after start. rf_wr_en never high.
- Restore with wait states: mem returns 0xA000+addr after 3 cycles of req; mode=1, first_reg=0, count=2, base_addr=0x0040.
  - Required: r0=0xA040, r1=0xA041.
  - Exactly one rf_wr_en pulse per register. mem_req and mem_addr held stable during waits.
- Wrap: save first_reg=14, count=4, base_addr=0xFFFE.
  - Required: rf_rd_idx sequence 14,15,0,1; mem_addr sequence 0xFFFE,0xFFFF,0x0000,0x0001.
- Degenerate counts:
  - count=0: done the cycle after start, mem_req never asserted.
  - count=20: exactly 16 transfers, r0..r15 once each.
- Interference: start pulsed while busy must not change range or addresses. mem_ack pulsed in IDLE produces no activity.
- Reset mid-restore: drop rst_n while in RST_REQ.
  - Required: busy, mem_req and rf_wr_en are 0 asynchronously and stay 0 after release.
  - A new command afterwards completes normally.
